// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_word_rx receiver.
// Defining UART_RX_PARITY_EN adds the PARITY state (8E1 framing).
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned BYTES_PER_WORD       = 4;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: rx synchronizer, bit FSM and baud counter.
// Build macro UART_RX_PARITY_EN selects 8E1 instead of 8N1.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)
(
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_byte,
    output logic                 o_byte_strobe,
    output logic                 o_err_strobe
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    rx_state_t            r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_armed;
    logic                 r_par_err;
    logic [15:0]          r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;

    logic w_rx;
    logic w_tick_half;
    logic w_tick_full;
    logic w_stop_sample;
    logic w_stop_ok;

    assign w_rx          = r_sync2;
    assign w_tick_half   = (r_cnt == HALF_M1);
    assign w_tick_full   = (r_cnt == FULL_M1);
    assign w_stop_sample = (r_state == ST_STOP) && w_tick_full;

`ifdef UART_RX_PARITY_EN
    assign w_stop_ok = w_rx && !r_par_err;
`else
    assign w_stop_ok = w_rx;
`endif

    // Strobes are decoded at the stop-sample edge so the word assembler can register them directly.
    assign o_byte        = r_shift;
    assign o_byte_strobe = w_stop_sample && w_stop_ok;
    assign o_err_strobe  = w_stop_sample && !w_stop_ok;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= ST_IDLE;
            r_armed   <= 1'b0;
            r_par_err <= 1'b0;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_rx) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_armed   <= 1'b0;
                        r_bit_idx <= '0;
                        r_par_err <= 1'b0;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick_half) begin
                        r_cnt   <= '0;
                        r_state <= w_rx ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_tick_full) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick_full) begin
                        r_cnt     <= '0;
                        r_par_err <= w_rx ^ (^r_shift);
                        r_state   <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_tick_full) begin
                        r_cnt   <= '0;
                        r_armed <= w_rx;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_word_rx.sv
// Host UART receiver packing four bytes per 32-bit word onto a valid/ready port.
// Build macro UART_RX_PARITY_EN selects 8E1 framing in the byte receiver.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_err,
    output logic        overrun
);

    localparam int unsigned CW = $clog2(BYTES_PER_WORD);

    logic [DATA_BITS-1:0]                    w_byte;
    logic                                    w_byte_strobe;
    logic                                    w_err_strobe;
    logic                                    w_last;
    logic                                    w_load;
    logic [CW-1:0]                           r_count;
    logic [DATA_BITS*(BYTES_PER_WORD-1)-1:0] r_lanes;
    logic [DATA_BITS*BYTES_PER_WORD-1:0]     r_word;
    logic                                    r_valid;
    logic                                    r_frame_err;
    logic                                    r_overrun;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
        .i_clock       (clock),
        .i_reset_n     (reset_n),
        .i_rx          (rx),
        .o_byte        (w_byte),
        .o_byte_strobe (w_byte_strobe),
        .o_err_strobe  (w_err_strobe)
    );

    assign w_last = w_byte_strobe && (r_count == CW'(BYTES_PER_WORD - 1));
    assign w_load = w_last && (!r_valid || word_ready);

    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_lanes     <= '0;
            r_word      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_err_strobe;
            r_overrun   <= w_last && !w_load;
            if (w_err_strobe) begin
                r_count <= '0;
            end else if (w_byte_strobe) begin
                r_count <= r_count + CW'(1);
                if (!w_last) begin
                    r_lanes[r_count*DATA_BITS +: DATA_BITS] <= w_byte;
                end
            end
            // A load on the transfer edge keeps valid high with the fresh word.
            if (w_load) begin
                r_word  <= {w_byte, r_lanes};
                r_valid <= 1'b1;
            end else if (r_valid && word_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_rx.sv
// Scoreboard bench for uart_word_rx: serial stimulus, queue-based reference, decoupled monitor.
`timescale 1ns/1ps
module tb_uart_word_rx;

    localparam int unsigned CPB = 8;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b1;
    logic        rx         = 1'b1;
    logic        word_ready = 1'b1;
    logic [31:0] word_out;
    logic        word_valid;
    logic        frame_err;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  partial[$];
    int exp_err = 0, exp_ovr = 0;
    int err_cycles = 0, err_edges = 0, ovr_cycles = 0, ovr_edges = 0;
    logic prev_err = 1'b0, prev_ovr = 1'b0;

    uart_word_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx         (rx),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: outputs and inputs are both stable at the falling edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            check("reset_word_out", word_out, 32'h0);
            check("reset_word_valid", 32'(word_valid), 32'h0);
            check("reset_frame_err", 32'(frame_err), 32'h0);
            check("reset_overrun", 32'(overrun), 32'h0);
        end else begin
            if (frame_err) err_cycles++;
            if (frame_err && !prev_err) err_edges++;
            if (overrun) ovr_cycles++;
            if (overrun && !prev_ovr) ovr_edges++;
            if (word_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h expected none", word_out);
                end else if (word_ready) begin
                    check("word", word_out, exp_q.pop_front());
                end else begin
                    check("held_word", word_out, exp_q[0]);
                end
            end
        end
        prev_err = frame_err;
        prev_ovr = overrun;
    end

    // Reference: whole bytes in, whole words out; a bad frame drops the partial word.
    task automatic model_byte(input logic [7:0] b, input bit good);
        logic [31:0] w;
        if (!good) begin
            partial.delete();
            exp_err++;
            return;
        end
        partial.push_back(b);
        if (partial.size() == 4) begin
            w = {partial[3], partial[2], partial[1], partial[0]};
            partial.delete();
            if (!word_ready && exp_q.size() != 0) exp_ovr++;
            else exp_q.push_back(w);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        wait_cycles(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit par_ok, input int gap);
        bit good;
        good = stop_ok;
`ifdef UART_RX_PARITY_EN
        good = good && par_ok;
`endif
        model_byte(b, good);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time((^b) ^ !par_ok);
`endif
        bit_time(stop_ok);
        rx = 1'b1;
        if (!stop_ok) wait_cycles(2 * CPB);
        if (gap > 0) wait_cycles(gap);
    endtask

    task automatic phase_end(input string name);
        rx = 1'b1;
        wait_cycles(3 * CPB);
        check({name, "_frame_err_pulses"}, 32'(err_edges), 32'(exp_err));
        check({name, "_frame_err_cycles"}, 32'(err_cycles), 32'(exp_err));
        check({name, "_overrun_pulses"}, 32'(ovr_edges), 32'(exp_ovr));
        check({name, "_overrun_cycles"}, 32'(ovr_cycles), 32'(exp_ovr));
        check({name, "_words_pending"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        logic [7:0] rb;
        #2 reset_n = 1'b0;
        wait_cycles(5);
        reset_n = 1'b1;
        wait_cycles(4 * CPB);

        send_byte(8'h78, 1, 1, 0);
        send_byte(8'h56, 1, 1, 0);
        send_byte(8'h34, 1, 1, 0);
        send_byte(8'h12, 1, 1, 0);
        phase_end("basic");

        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h11, 1, 1, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h22, 1, 1, 0);
        wait_cycles(2 * CPB);
        check("hold_valid", 32'(word_valid), 32'h1);
        check("hold_word_out", word_out, 32'h11111111);
        word_ready = 1'b1;
        phase_end("overrun");

        send_byte(8'h9A, 1, 1, 0);
        send_byte(8'hBC, 1, 1, 0);
        send_byte(8'hAA, 0, 1, 0);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1, 1, 0);
        phase_end("stop_err");

        rx = 1'b0;
        wait_cycles(3);
        rx = 1'b1;
        phase_end("glitch");

        send_byte(8'h55, 1, 1, 0);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        wait_cycles(3);
        reset_n = 1'b0;
        rx = 1'b1;
        partial.delete();
        wait_cycles(4);
        reset_n = 1'b1;
        wait_cycles(2 * CPB);
        send_byte(8'hDE, 1, 1, 0);
        send_byte(8'hAD, 1, 1, 0);
        send_byte(8'hBE, 1, 1, 0);
        send_byte(8'hEF, 1, 1, 0);
        phase_end("reset_abort");

`ifdef UART_RX_PARITY_EN
        send_byte(8'h03, 1, 0, 0);
        send_byte(8'h03, 1, 1, 0);
        send_byte(8'h04, 1, 1, 0);
        send_byte(8'h05, 1, 1, 0);
        send_byte(8'h06, 1, 1, 0);
        phase_end("parity");
`endif

        for (int i = 0; i < 60; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_byte(rb, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                      int'($urandom_range(0, 12)));
        end
        phase_end("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Serial work-loading receiver for the miner datapath. Samples an asynchronous 8N1 UART line from the host, recovers bytes, packs every four bytes into a 32-bit word, and presents each word on a valid/ready interface to the header/nonce loading logic. It is the inbound counterpart of the result-reporting path and is the only block on the FPGA that touches the host RX pin.

## Interface
- CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 8..65535
- clock  input  1  system clock; all state on the rising edge
- reset_n  input  1  reset, asynchronous and active-low
- rx  input  1  raw UART line, idle high, asynchronous to clock
- word_out  output  32  assembled word; first received byte in [7:0], fourth in [31:24]
- word_valid  output  1  word_out holds an unconsumed word
- word_ready  input  1  consumer accepts word_out when high with word_valid
- frame_err  output  1  one-cycle pulse on a bad stop bit (or parity, see Configuration)
- overrun  output  1  one-cycle pulse when a completed word is dropped

## Operation
- rx passes through a 2-flop synchronizer; both flops reset to 1.
- Bit FSM states: IDLE, START, DATA, STOP (PARITY inserted before STOP with the macro).
- IDLE: arms only after the synchronized line reads 1; a 1->0 transition moves to START with bit counter cleared.
- START: waits CLKS_PER_BIT/2 (integer division) cycles, resamples; 0 -> DATA, 1 -> IDLE (glitch, no error).
- DATA: samples every CLKS_PER_BIT cycles, LSB first, 8 bits into a shift register.
- STOP: samples after CLKS_PER_BIT cycles; 1 -> byte accepted; 0 -> frame_err pulse, byte discarded, word byte count cleared to 0 (partial word discarded); returns to IDLE in both cases.
- Word assembler: 2-bit byte count, wraps 3->0; accepted byte written into lane count*8.
- On the 4th byte: if word_valid=0 or word_ready=1 in that cycle, word loads into word_out and word_valid is 1. Otherwise the new word is dropped, overrun pulses, word_out/word_valid are unchanged.
- Handshake: transfer occurs on the edge with word_valid=1 and word_ready=1; word_valid clears unless a new word loads on the same edge (then it stays 1 with the new data). word_out is stable while word_valid=1 and word_ready=0.

## Timing
- Reset values: word_out=0, word_valid=0, frame_err=0, overrun=0, FSM=IDLE, byte count=0, all counters 0.
- Reset assertion mid-frame aborts immediately; after release, the first frame is recognized only after rx has been seen high in IDLE.
- Word latency: word_valid rises the cycle after the 4th byte's stop-bit sample edge.
- frame_err and overrun rise the cycle after the offending sample and last exactly one cycle.
- Sample points: start bit at CLKS_PER_BIT/2, bit n at CLKS_PER_BIT/2 + (n+1)*CLKS_PER_BIT cycles after the synchronized falling edge (plus 2-cycle synchronizer delay relative to the pin).
- Back-to-back frames with no idle gap are received without loss.

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1; one even-parity bit follows bit 7 and is sampled in PARITY; a mismatch sets a sticky flag and the STOP state then behaves as a bad stop bit (frame_err pulse, byte and partial word discarded).
- Undefined: 8N1, no PARITY state, no parity logic. Port list is identical in both builds.

## Structure
- Shared package uart_pkg: FSM state enum, DATA_BITS=8, BYTES_PER_WORD=4, default CLKS_PER_BIT constant.
- One sub-module, uart_byte_rx: synchronizer, bit FSM and baud counter, outputs byte/byte_strobe/err_strobe. The top level holds only the word assembler and the output handshake.

## Test plan
- CLKS_PER_BIT=8; send bytes 0x78,0x56,0x34,0x12, word_ready=1 -> one word_valid cycle with word_out=0x12345678, no error pulses.
- Hold word_ready=0; send 8 bytes (words 0x11111111 then 0x22222222) -> word_out stays 0x11111111, overrun pulses once, word_valid stays 1.
- Send 0xAA with stop bit forced 0 mid-word (after 2 good bytes), then 4 good bytes 0x01..0x04 -> one frame_err pulse, then word_out=0x04030201.
- 3-cycle low glitch on idle rx -> no byte, no error, FSM back in IDLE.
- Assert reset_n low during the DATA bits of byte 2, release, send 4 bytes 0xDE,0xAD,0xBE,0xEF -> word_out=0xEFBEADDE and all outputs 0 during reset.
- With UART_RX_PARITY_EN: byte 0x03 sent with parity bit 1 -> frame_err pulse; with parity bit 0 -> byte accepted.
